// File: rtl/code_lock_pkg.sv
// Shared state constants, digit type and digit validation for the parametrised code lock.
package code_lock_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_ENTRY   = 2'd0;
   localparam state_t ST_OPEN    = 2'd1;
   localparam state_t ST_PROG    = 2'd2;
   localparam state_t ST_LOCKOUT = 2'd3;

   typedef logic [3:0] digit_t;

   localparam digit_t MAX_DIGIT = 4'd9;

   function automatic logic is_valid_digit(input digit_t digit);
      return digit <= MAX_DIGIT;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter: i_start loads a cycle count, o_done is high during the last counted cycle.
module lock_timer
   import code_lock_pkg::*;
#(
   parameter int p_width = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_clear,
   input  logic [p_width-1:0] i_load_val,
   output logic               o_done
);

   logic [p_width-1:0] count;

   // Start beats clear; an idle counter parks at zero rather than wrapping.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         count <= '0;
      end else if (i_start) begin
         count <= i_load_val;
      end else if (i_clear) begin
         count <= '0;
      end else if (count != '0) begin
         count <= count - p_width'(1);
      end
   end

   assign o_done = (count == p_width'(1));

endmodule

// File: rtl/code_lock_fsm_n.sv
// N-digit code lock with runtime reprogramming, retry lockout and optional auto-relock.
// Define CODE_LOCK_TIMEOUT_EN to clear partial entries after an inter-digit timeout.
module code_lock_fsm_n
   import code_lock_pkg::*;
#(
   parameter int          p_digits       = 4,
   parameter logic [31:0] p_default_code = 32'h0000_1234,
   parameter int          p_max_tries    = 3,
   parameter int          p_lockout_cyc  = 50_000_000,
   parameter int          p_open_cyc     = 0,
   parameter int          p_digit_to_cyc = 250_000_000
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic [3:0]                         i_code,
   input  logic                               i_code_vld,
   input  logic                               i_close,
   input  logic                               i_prog,
   output logic                               o_open,
   output logic                               o_prog,
   output logic                               o_lockout,
   output logic                               o_fail,
   output logic [$clog2(p_max_tries+1)-1:0]   o_tries_left,
   output logic [4*p_digits-1:0]              o_entry,
   output logic [$clog2(p_digits+1)-1:0]      o_entry_cnt
);

   localparam int c_tw     = $clog2(p_max_tries + 1);
   localparam int c_cw     = $clog2(p_digits + 1);
   localparam int c_ew     = 4 * p_digits;
   localparam int c_lock_w = $clog2(p_lockout_cyc + 1);
   localparam int c_open_w = (p_open_cyc > 0) ? $clog2(p_open_cyc + 1) : 1;

   localparam logic [c_tw-1:0] c_tries_max = c_tw'(p_max_tries);
   localparam logic [c_tw-1:0] c_one_try   = c_tw'(1);
   localparam logic [c_cw-1:0] c_last_cnt  = c_cw'(p_digits - 1);

   state_t            state;
   logic [c_ew-1:0]   code_reg;
   logic [c_ew-1:0]   entry;
   logic [c_cw-1:0]   entry_cnt;
   logic [c_tw-1:0]   tries;
   logic              fail;

   logic [c_ew-1:0]   digit_ext;
   logic [c_ew-1:0]   shifted;
   logic              collecting;
   logic              accept;
   logic              complete;
   logic              code_match;
   logic              lock_start;
   logic              open_start;
   logic              open_clear;
   logic              lock_done;
   logic              open_done;
   logic              timeout_hit;

   // A close always wins over a digit arriving in the same cycle.
   always_comb begin
      digit_ext      = '0;
      digit_ext[3:0] = i_code;
      shifted        = (entry << 4) | digit_ext;
      collecting     = (state == ST_ENTRY) || (state == ST_PROG);
      accept         = collecting && !i_close && i_code_vld && is_valid_digit(i_code);
      complete       = accept && (entry_cnt == c_last_cnt);
      code_match     = (shifted == code_reg);
      lock_start     = complete && (state == ST_ENTRY) && !code_match && (tries <= c_one_try);
      open_start     = complete && ((state == ST_PROG) || code_match);
      open_clear     = (state == ST_OPEN) && (i_close || i_prog);
   end

   lock_timer #(.p_width(c_lock_w)) u_lock_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_start    (lock_start),
      .i_clear    (1'b0),
      .i_load_val (c_lock_w'(p_lockout_cyc)),
      .o_done     (lock_done)
   );

   // With p_open_cyc = 0 the timer is loaded with zero and never fires.
   lock_timer #(.p_width(c_open_w)) u_open_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_start    (open_start),
      .i_clear    (open_clear),
      .i_load_val (c_open_w'(p_open_cyc)),
      .o_done     (open_done)
   );

`ifdef CODE_LOCK_TIMEOUT_EN
   localparam int c_dto_w = $clog2(p_digit_to_cyc + 1);

   logic dto_start;
   logic dto_clear;
   logic dto_done;

   assign dto_start = accept && !complete;
   assign dto_clear = complete || (collecting && i_close);

   lock_timer #(.p_width(c_dto_w)) u_digit_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_start    (dto_start),
      .i_clear    (dto_clear),
      .i_load_val (c_dto_w'(p_digit_to_cyc)),
      .o_done     (dto_done)
   );

   assign timeout_hit = dto_done && collecting && (entry_cnt != '0);
`else
   // No inter-digit timeout here; the parameter only keeps the interface uniform.
   assign timeout_hit = (p_digit_to_cyc < 0);
`endif

   // Main lock FSM; a complete entry is judged on the edge that samples its last digit.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state     <= ST_ENTRY;
         code_reg  <= p_default_code[c_ew-1:0];
         entry     <= '0;
         entry_cnt <= '0;
         tries     <= c_tries_max;
         fail      <= 1'b0;
      end else begin
         fail <= 1'b0;
         case (state)
            ST_ENTRY, ST_PROG: begin
               if (i_close) begin
                  entry     <= '0;
                  entry_cnt <= '0;
                  state     <= ST_ENTRY;
               end else if (complete) begin
                  entry     <= '0;
                  entry_cnt <= '0;
                  if (state == ST_PROG) begin
                     code_reg <= shifted;
                     state    <= ST_OPEN;
                  end else if (code_match) begin
                     state <= ST_OPEN;
                     tries <= c_tries_max;
                  end else begin
                     fail <= 1'b1;
                     if (lock_start) begin
                        tries <= '0;
                        state <= ST_LOCKOUT;
                     end else begin
                        tries <= tries - c_one_try;
                     end
                  end
               end else if (accept) begin
                  entry     <= shifted;
                  entry_cnt <= entry_cnt + c_cw'(1);
               end else if (timeout_hit) begin
                  entry     <= '0;
                  entry_cnt <= '0;
               end
            end
            ST_OPEN: begin
               if (i_close) begin
                  state <= ST_ENTRY;
               end else if (i_prog) begin
                  state <= ST_PROG;
               end else if (open_done) begin
                  state <= ST_ENTRY;
               end
            end
            ST_LOCKOUT: begin
               if (lock_done) begin
                  state <= ST_ENTRY;
                  tries <= c_tries_max;
               end
            end
            default: begin
               state <= ST_ENTRY;
            end
         endcase
      end
   end

   assign o_open       = (state == ST_OPEN) || (state == ST_PROG);
   assign o_prog       = (state == ST_PROG);
   assign o_lockout    = (state == ST_LOCKOUT);
   assign o_fail       = fail;
   assign o_tries_left = tries;
   assign o_entry      = entry;
   assign o_entry_cnt  = entry_cnt;

endmodule

// File: tb/tb_code_lock_fsm_n.sv
// Self-checking bench for code_lock_fsm_n: directed scenarios plus random traffic against a digit-queue model.
module tb_code_lock_fsm_n;

   localparam int P     = 4;
   localparam int MAXT  = 3;
   localparam int LOCK  = 20;
   localparam int OPENC = 10;
   localparam int DTO   = 8;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic [3:0]  i_code = 4'd0;
   logic        i_code_vld = 1'b0;
   logic        i_close = 1'b0;
   logic        i_prog = 1'b0;
   logic        o_open;
   logic        o_prog;
   logic        o_lockout;
   logic        o_fail;
   logic [1:0]  o_tries_left;
   logic [15:0] o_entry;
   logic [2:0]  o_entry_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   always #5 i_clk = ~i_clk;

   code_lock_fsm_n #(
      .p_digits       (P),
      .p_default_code (32'h0000_1234),
      .p_max_tries    (MAXT),
      .p_lockout_cyc  (LOCK),
      .p_open_cyc     (OPENC),
      .p_digit_to_cyc (DTO)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_code       (i_code),
      .i_code_vld   (i_code_vld),
      .i_close      (i_close),
      .i_prog       (i_prog),
      .o_open       (o_open),
      .o_prog       (o_prog),
      .o_lockout    (o_lockout),
      .o_fail       (o_fail),
      .o_tries_left (o_tries_left),
      .o_entry      (o_entry),
      .o_entry_cnt  (o_entry_cnt)
   );

   // Behavioural model: digits held in a queue, the stored code as a digit list, plain countdowns.
   int m_buf[$];
   int m_code[$];
   int m_tries;
   int m_lock_left;
   int m_open_age;
   int m_idle;
   bit m_open;
   bit m_prog;
   bit m_fail;

   function automatic void modelReset();
      m_buf.delete();
      m_code      = '{1, 2, 3, 4};
      m_tries     = MAXT;
      m_lock_left = 0;
      m_open_age  = 0;
      m_idle      = 0;
      m_open      = 1'b0;
      m_prog      = 1'b0;
      m_fail      = 1'b0;
   endfunction

   function automatic void modelStep(input bit vld, input int digit, input bit close, input bit prog);
      bit same;
      m_fail = 1'b0;
      if (m_lock_left > 0) begin
         m_lock_left--;
         if (m_lock_left == 0) m_tries = MAXT;
      end else if (m_open && !m_prog) begin
         if (close) m_open = 1'b0;
         else if (prog) m_prog = 1'b1;
         else if (OPENC != 0) begin
            m_open_age++;
            if (m_open_age >= OPENC) m_open = 1'b0;
         end
      end else if (close) begin
         m_buf.delete();
         m_open = 1'b0;
         m_prog = 1'b0;
      end else if (vld && digit <= 9) begin
         m_buf.push_back(digit);
         m_idle = 0;
         if (m_buf.size() == P) begin
            same = 1'b1;
            for (int i = 0; i < P; i++) if (m_buf[i] != m_code[i]) same = 1'b0;
            if (m_prog) begin
               m_code     = m_buf;
               m_prog     = 1'b0;
               m_open_age = 0;
            end else if (same) begin
               m_open     = 1'b1;
               m_open_age = 0;
               m_tries    = MAXT;
            end else begin
               m_fail = 1'b1;
               m_tries--;
               if (m_tries == 0) m_lock_left = LOCK;
            end
            m_buf.delete();
         end
      end else if (m_buf.size() > 0) begin
         m_idle++;
`ifdef CODE_LOCK_TIMEOUT_EN
         if (m_idle >= DTO) m_buf.delete();
`endif
      end
   endfunction

   function automatic logic [15:0] modelEntry();
      logic [15:0] e;
      e = '0;
      foreach (m_buf[i]) e = (e << 4) | 16'(m_buf[i]);
      return e;
   endfunction

   always @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) modelReset();
      else modelStep(i_code_vld, int'(i_code), i_close, i_prog);
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: actual=%0h required=%0h time=%0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge i_clk) begin
      if (cmp_en) begin
         checkOutput("open",       32'(o_open),       32'(m_open));
         checkOutput("prog",       32'(o_prog),       32'(m_prog));
         checkOutput("lockout",    32'(o_lockout),    32'(m_lock_left > 0));
         checkOutput("fail",       32'(o_fail),       32'(m_fail));
         checkOutput("tries_left", 32'(o_tries_left), 32'(m_tries));
         checkOutput("entry",      32'(o_entry),      32'(modelEntry()));
         checkOutput("entry_cnt",  32'(o_entry_cnt),  32'(m_buf.size()));
      end
   end

   task automatic applyStimulus(input bit vld, input logic [3:0] digit, input bit close, input bit prog);
      i_code_vld = vld;
      i_code     = digit;
      i_close    = close;
      i_prog     = prog;
      @(posedge i_clk);
      #1;
      i_code_vld = 1'b0;
      i_close    = 1'b0;
      i_prog     = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic enterCode(input int d0, input int d1, input int d2, input int d3);
      applyStimulus(1'b1, 4'(d0), 1'b0, 1'b0);
      applyStimulus(1'b1, 4'(d1), 1'b0, 1'b0);
      applyStimulus(1'b1, 4'(d2), 1'b0, 1'b0);
      applyStimulus(1'b1, 4'(d3), 1'b0, 1'b0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_open"},    32'(o_open),       32'd0);
      checkOutput({tag, "_prog"},    32'(o_prog),       32'd0);
      checkOutput({tag, "_lockout"}, 32'(o_lockout),    32'd0);
      checkOutput({tag, "_fail"},    32'(o_fail),       32'd0);
      checkOutput({tag, "_tries"},   32'(o_tries_left), 32'd3);
      checkOutput({tag, "_entry"},   32'(o_entry),      32'd0);
      checkOutput({tag, "_cnt"},     32'(o_entry_cnt),  32'd0);
   endtask

   initial begin
      #500_000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cycles;
      int kind;
      int snap[$];

      modelReset();
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      i_rst  = 1'b1;
      cmp_en = 1'b1;
      @(posedge i_clk);
      #1;
      checkResetValues("reset");

      // Default code opens one cycle after the fourth digit.
      applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd2, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
      checkOutput("partial_entry", 32'(o_entry), 32'h0123);
      checkOutput("partial_cnt", 32'(o_entry_cnt), 32'd3);
      checkOutput("partial_closed", 32'(o_open), 32'd0);
      applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
      checkOutput("open_1234", 32'(o_open), 32'd1);
      checkOutput("open_tries", 32'(o_tries_left), 32'd3);
      checkOutput("open_cnt", 32'(o_entry_cnt), 32'd0);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
      checkOutput("closed", 32'(o_open), 32'd0);

      // Three wrong entries lead to a lockout that ignores all input.
      for (int k = 0; k < 3; k++) begin
         enterCode(1, 2, 3, 5);
         checkOutput("wrong_fail", 32'(o_fail), 32'd1);
         checkOutput("wrong_tries", 32'(o_tries_left), 32'(2 - k));
      end
      checkOutput("lockout_on", 32'(o_lockout), 32'd1);
      cycles = 0;
      while (o_lockout === 1'b1 && cycles < 100) begin
         cycles++;
         applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      checkOutput("lockout_len", 32'(cycles), 32'(LOCK));
      checkOutput("lockout_tries", 32'(o_tries_left), 32'd3);
      checkOutput("lockout_cnt", 32'(o_entry_cnt), 32'd0);
      enterCode(1, 2, 3, 4);
      checkOutput("reopen", 32'(o_open), 32'd1);

      // Reprogram to 9876, then the old code fails and the new one opens.
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      checkOutput("prog_on", 32'(o_prog), 32'd1);
      checkOutput("prog_open", 32'(o_open), 32'd1);
      enterCode(9, 8, 7, 6);
      checkOutput("prog_off", 32'(o_prog), 32'd0);
      checkOutput("prog_still_open", 32'(o_open), 32'd1);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
      enterCode(1, 2, 3, 4);
      checkOutput("old_code_fail", 32'(o_fail), 32'd1);
      checkOutput("old_code_tries", 32'(o_tries_left), 32'd2);
      enterCode(9, 8, 7, 6);
      checkOutput("new_code_open", 32'(o_open), 32'd1);
      checkOutput("new_code_tries", 32'(o_tries_left), 32'd3);

      // Close and prog together in OPEN: close wins.
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
      checkOutput("close_prog_open", 32'(o_open), 32'd0);
      checkOutput("close_prog_prog", 32'(o_prog), 32'd0);

      // Invalid digit dropped; close beats a concurrent digit.
      applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'hA, 1'b0, 1'b0);
      checkOutput("bad_digit_cnt", 32'(o_entry_cnt), 32'd1);
      checkOutput("bad_digit_entry", 32'(o_entry), 32'h0001);
      applyStimulus(1'b1, 4'd5, 1'b1, 1'b0);
      checkOutput("close_digit_cnt", 32'(o_entry_cnt), 32'd0);
      checkOutput("close_digit_entry", 32'(o_entry), 32'd0);
      applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
      checkOutput("two_then_close", 32'(o_entry_cnt), 32'd0);

      // Auto-relock after OPENC cycles.
      enterCode(9, 8, 7, 6);
      cycles = 0;
      while (o_open === 1'b1 && cycles < 100) begin
         cycles++;
         idle(1);
      end
      checkOutput("relock_len", 32'(cycles), 32'(OPENC));

      // Partial entry idle behaviour.
      applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd2, 1'b0, 1'b0);
      idle(DTO - 1);
      checkOutput("idle_before_to", 32'(o_entry_cnt), 32'd2);
      idle(1);
`ifdef CODE_LOCK_TIMEOUT_EN
      checkOutput("idle_at_to", 32'(o_entry_cnt), 32'd0);
`else
      checkOutput("idle_at_to", 32'(o_entry_cnt), 32'd2);
`endif
      checkOutput("idle_tries", 32'(o_tries_left), 32'd3);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);

      // Reset asserted during lockout takes effect immediately and restores the default code.
      for (int k = 0; k < 3; k++) enterCode(1, 2, 3, 5);
      idle(3);
      checkOutput("pre_reset_lockout", 32'(o_lockout), 32'd1);
      #2;
      i_rst = 1'b0;
      #1;
      checkResetValues("async_reset");
      @(negedge i_clk);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      enterCode(1, 2, 3, 4);
      checkOutput("default_restored", 32'(o_open), 32'd1);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);

      // Random traffic checked cycle by cycle against the model.
      for (int b = 0; b < 300; b++) begin
         kind = $urandom_range(0, 9);
         snap = m_code;
         case (kind)
            0, 1, 2: begin
               for (int i = 0; i < P; i++)
                  applyStimulus(1'b1, 4'(snap[i]), 1'($urandom_range(0, 29) == 0), 1'b0);
            end
            3, 4: begin
               for (int i = 0; i < P; i++)
                  applyStimulus(1'b1, 4'($urandom_range(0, 9)), 1'b0, 1'b0);
            end
            5: applyStimulus(1'b1, 4'($urandom_range(10, 15)), 1'b0, 1'b0);
            6: applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
            7: begin
               applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
               for (int i = 0; i < P; i++)
                  applyStimulus(1'b1, 4'($urandom_range(0, 9)), 1'b0, 1'b0);
            end
            8: idle($urandom_range(1, 12));
            default: applyStimulus(1'b1, 4'($urandom_range(0, 9)), 1'b1, 1'($urandom_range(0, 1)));
         endcase
      end

      idle(2);
      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/code_lock_fsm_n.md
Name: code_lock_fsm_n

Overview:
Parametrised successor to the fixed 4-digit lock FSM. It accepts a stream of decoded decimal digits (one per valid strobe) and compares an N-digit entry against a stored code. The code is reprogrammable at runtime, and the block adds a retry limit with timed lockout and an optional auto-relock.
It sits between the switch-driver/decoder and the 7-segment display path, and exposes the entry buffer for display.

Parameters:
p_digits, 4, code length in decimal digits (1..8)
p_default_code, 32'h0000_1234, reset code, packed BCD, digit 0 in bits [3:0]; only low 4*p_digits bits used
p_max_tries, 3, wrong entries allowed before lockout (>=1)
p_lockout_cyc, 50_000_000, lockout duration in clock cycles (>=1)
p_open_cyc, 0, auto-relock after this many cycles in OPEN; 0 = disabled
p_digit_to_cyc, 250_000_000, inter-digit timeout (used only with CODE_LOCK_TIMEOUT_EN)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-low reset
i_code  in  4  decoded digit
i_code_vld  in  1  one-cycle strobe, i_code valid
i_close  in  1  level/pulse: relock or abort
i_prog  in  1  pulse: enter code-programming mode (honoured only in OPEN)
o_open  out  1  lock open
o_prog  out  1  programming mode active
o_lockout  out  1  lockout active, input ignored
o_fail  out  1  one-cycle pulse on wrong complete entry
o_tries_left  out  $clog2(p_max_tries+1)  remaining attempts
o_entry  out  4*p_digits  entry buffer, packed BCD, newest digit in [3:0]
o_entry_cnt  out  $clog2(p_digits+1)  digits entered so far

Behaviour:
- Reset (async assert, sync release): state ENTRY, code register = p_default_code, o_entry = 0, o_entry_cnt = 0, o_tries_left = p_max_tries; o_open/o_prog/o_lockout/o_fail = 0.
- Digits with i_code > 9 are dropped, with no state change.
- ENTRY: each valid digit shifts into o_entry (shift left by 4, new digit into [3:0]) and increments o_entry_cnt.
  - On the edge sampling the p_digits-th digit, the full entry (buffer + incoming digit) is compared to the code register. Result is registered, 1-cycle latency.
  - Match: OPEN next cycle, o_tries_left reloaded, buffer cleared.
  - Mismatch: o_fail pulses, o_tries_left decrements, buffer cleared. If o_tries_left reaches 0 -> LOCKOUT, else stay in ENTRY.
- LOCKOUT: o_lockout = 1; all digits, i_close and i_prog ignored. After exactly p_lockout_cyc cycles -> ENTRY, o_tries_left = p_max_tries.
- OPEN: o_open = 1; digits ignored.
  - i_close -> ENTRY next cycle.
  - i_prog -> PROG.
  - If p_open_cyc != 0: after p_open_cyc cycles in OPEN with no i_prog -> ENTRY (timer restarts on each OPEN entry).
- PROG: o_open = 1, o_prog = 1. Digits fill the buffer.
  - After p_digits digits, the buffer is committed to the code register in the same edge; buffer cleared; -> OPEN.
  - i_close aborts: old code kept, buffer cleared, -> ENTRY.
- Simultaneous events:
  - i_close with i_code_vld in ENTRY/PROG: close wins, digit dropped, buffer cleared.
  - i_close and i_prog together in OPEN: close wins.
  - Reset mid-operation: returns to the reset state; a programmed code is lost (reverts to p_default_code).
- Counters saturate, never wrap. The lockout timer is $clog2(p_lockout_cyc+1) bits.

Optional Feature:
CODE_LOCK_TIMEOUT_EN
- Defined: in ENTRY/PROG, with o_entry_cnt > 0, p_digit_to_cyc cycles without a valid digit clears the partial buffer. This consumes no try; PROG stays in PROG. The timer restarts on each accepted digit.
- Undefined: partial entries persist indefinitely; timer logic absent.

Decomposition:
- Package code_lock_pkg: state enum (ENTRY, OPEN, PROG, LOCKOUT), digit type logic [3:0], constant for max digit value 9.
- One sub-module, lock_timer: loadable down-counter with start/clear and a done pulse. It is instanced for lockout, auto-relock and (optionally) the inter-digit timeout.

Test Plan:
- Default code 1234, p_digits=4: strobe 1,2,3,4 -> o_open=1 one cycle after the 4th strobe; o_tries_left=3.
- Enter 1,2,3,5 three times (p_max_tries=3) -> o_fail pulses each time; o_tries_left 2,1,0; o_lockout=1 for exactly p_lockout_cyc (test value 20); then correct code opens.
- OPEN, i_prog, enter 9,8,7,6 -> o_prog falls, code updated; i_close; 1,2,3,4 fails; 9,8,7,6 opens.
- Enter digit 0xA and strobe i_close mid-entry: 0xA ignored (o_entry_cnt unchanged); close clears the buffer; 2 digits then close -> o_entry_cnt=0.
- p_open_cyc=10: open, wait 10 cycles -> o_open=0. Assert i_rst low during LOCKOUT -> all outputs at reset values immediately.
- With CODE_LOCK_TIMEOUT_EN, p_digit_to_cyc=8: enter 1,2, idle 8 cycles -> o_entry_cnt=0, o_tries_left unchanged.
